// File: rtl/guvm_wb_slave_mem.sv
// Wishbone classic slave memory for the Amber 128-bit master port.
// Responds with ack (in range) or err (out of range) after a configurable
// number of wait states. Tracks per-word validity so never-written bytes
// read back as FILL_WORD. A backdoor port preloads whole words.
module guvm_wb_slave_mem #(
  parameter int             DEPTH       = 256,
  parameter int             WAIT_CYCLES = 2,
  parameter logic [31:0]    BASE_ADR    = 32'h0000_0000,
  parameter logic [127:0]   FILL_WORD   = 128'hF0801003F0801003F0801003F0801003
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_wb_adr,
  input  logic [15:0]              i_wb_sel,
  input  logic                     i_wb_we,
  input  logic [127:0]             i_wb_dat,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic [127:0]             o_wb_dat,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  input  logic                     i_ld_valid,
  input  logic [$clog2(DEPTH)-1:0] i_ld_adr,
  input  logic [127:0]             i_ld_dat,
  output logic                     o_busy,
  output logic [15:0]              o_access_count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [32:0] SPAN    = 33'(DEPTH) * 33'd16;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [DEPTH-1:0] r_valid;
  logic [127:0]    r_mem [DEPTH];

  // Request fields held for the duration of the wait states.
  logic [AW-1:0]   r_idx;
  logic [15:0]     r_sel;
  logic            r_we;
  logic [127:0]    r_dat;
  logic            r_in_range;

  // Live decode of the bus address.
  logic            w_req;
  logic [31:0]     w_off;
  logic            w_dec_in_range;
  logic [AW-1:0]   w_dec_idx;

  assign w_req          = i_wb_cyc & i_wb_stb;
  assign w_off          = i_wb_adr - BASE_ADR;
  assign w_dec_in_range = (i_wb_adr >= BASE_ADR) && ({1'b0, w_off} < SPAN);
  assign w_dec_idx      = w_off[AW+3:4];

  // With zero wait states the response is taken straight from the bus;
  // otherwise it comes from the captured request.
  logic            w_idle;
  logic [AW-1:0]   w_idx;
  logic [15:0]     w_sel;
  logic            w_we;
  logic [127:0]    w_dat;
  logic            w_in_range;

  assign w_idle     = (r_state == S_IDLE);
  assign w_idx      = w_idle ? w_dec_idx      : r_idx;
  assign w_sel      = w_idle ? i_wb_sel       : r_sel;
  assign w_we       = w_idle ? i_wb_we        : r_we;
  assign w_dat      = w_idle ? i_wb_dat       : r_dat;
  assign w_in_range = w_idle ? w_dec_in_range : r_in_range;

  // Edge at which the FSM enters RESP; abort (cyc/stb low) never gets here.
  logic w_resp_entry;
  assign w_resp_entry = w_req &&
                        ((w_idle && (WAIT_CYCLES == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd1)));

  logic         w_wr_en;
  logic [127:0] w_cur;
  logic [127:0] w_merged;

  assign w_wr_en = w_resp_entry && w_we && w_in_range;
  assign w_cur   = r_valid[w_idx] ? r_mem[w_idx] : FILL_WORD;

  // Byte merge: same-edge preload lands first, selected core bytes on top.
  always_comb begin
    w_merged = w_cur;
    if (i_ld_valid && (i_ld_adr == w_idx))
      w_merged = i_ld_dat;
    for (int b = 0; b < 16; b++)
      if (w_sel[b]) w_merged[8*b +: 8] = w_dat[8*b +: 8];
  end

  // Capture the request in IDLE; contents only matter while not IDLE.
  always_ff @(posedge i_clk) begin
    if (w_idle && w_req) begin
      r_idx      <= w_dec_idx;
      r_sel      <= i_wb_sel;
      r_we       <= i_wb_we;
      r_dat      <= i_wb_dat;
      r_in_range <= w_dec_in_range;
    end
  end

  // Storage array: preload port and core write port.
  // NOTE: the array is deliberately not reset; r_valid supplies the
  // post-reset FILL_WORD view, so this maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (i_ld_valid) r_mem[i_ld_adr] <= i_ld_dat;
      // NOTE: on a same-index collision this later nonblocking write wins;
      // w_merged already contains the preload data underneath.
      if (w_wr_en) r_mem[w_idx] <= w_merged;
    end
  end

  // Control FSM with registered response, busy, counter and validity bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_valid        <= '0;
      o_wb_dat       <= '0;
      o_wb_ack       <= 1'b0;
      o_wb_err       <= 1'b0;
      o_busy         <= 1'b0;
      o_access_count <= 16'd0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      if (i_ld_valid) r_valid[i_ld_adr] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_req && (WAIT_CYCLES != 0)) begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_LD;
            o_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase

      if (w_resp_entry) begin
        r_state        <= S_RESP;
        o_busy         <= 1'b1;
        o_access_count <= o_access_count + 16'd1;
        if (w_in_range) begin
          o_wb_ack <= 1'b1;
          if (w_we) r_valid[w_idx] <= 1'b1;
          else      o_wb_dat       <= w_cur;
        end else begin
          o_wb_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_guvm_wb_slave_mem.sv
// Directed bench for guvm_wb_slave_mem: instance u_a uses the default
// configuration (2 wait states, 256 words); instance u_b uses 0 wait states
// and 16 words for back-to-back and counter wrap scenarios.
module tb_guvm_wb_slave_mem;

  localparam logic [127:0] FILL = 128'hF0801003F0801003F0801003F0801003;
  localparam int           WA   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  adr;
  logic [15:0]  sel;
  logic         we;
  logic [127:0] dat;
  logic         cyc, stb;
  logic         b_cyc, b_stb;
  logic         ld_valid;
  logic [7:0]   ld_adr;
  logic [127:0] ld_dat;

  logic [127:0] a_dat, b_dat;
  logic         a_ack, a_err, a_busy, b_ack, b_err, b_busy;
  logic [15:0]  a_cnt, b_cnt;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_cnt;
  logic [127:0] exp_dat;

  guvm_wb_slave_mem u_a (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(dat),
    .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_dat(a_dat), .o_wb_ack(a_ack), .o_wb_err(a_err),
    .i_ld_valid(ld_valid), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat),
    .o_busy(a_busy), .o_access_count(a_cnt)
  );

  guvm_wb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(dat),
    .i_wb_cyc(b_cyc), .i_wb_stb(b_stb),
    .o_wb_dat(b_dat), .o_wb_ack(b_ack), .o_wb_err(b_err),
    .i_ld_valid(1'b0), .i_ld_adr(4'd0), .i_ld_dat(128'd0),
    .o_busy(b_busy), .o_access_count(b_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic preload(input logic [7:0] idx, input logic [127:0] d);
    @(negedge clk);
    ld_adr = idx; ld_dat = d; ld_valid = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // One u_a transaction. lat = negedges after the capture edge until the
  // response is seen (expected WA, i.e. master samples at capture+1+WA).
  // pre_ld raises the preload strobe for the RESP entry edge only.
  task automatic xfer(input logic [31:0] a, input logic [15:0] s,
                      input logic w, input logic [127:0] d, input bit pre_ld,
                      output logic got_ack, output logic got_err,
                      output int lat, output int busy_n);
    @(negedge clk);
    adr = a; sel = s; we = w; dat = d; cyc = 1'b1; stb = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; lat = -1; busy_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_busy) busy_n++;
      ld_valid = pre_ld && (n == WA - 1);
      if (a_ack || a_err) begin
        got_ack = a_ack; got_err = a_err; lat = n;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL resp_single_cycle @%0h: ack=%b err=%b busy=%b, want 0 0 0",
               a, a_ack, a_err, a_busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({a_dat, a_ack, a_err, a_busy, a_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_a: dat=%h ack=%b err=%b busy=%b cnt=%h, want all 0",
               a_dat, a_ack, a_err, a_busy, a_cnt);
    end
    checks++;
    if ({b_dat, b_ack, b_err, b_busy, b_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_b: dat=%h ack=%b err=%b busy=%b cnt=%h, want all 0",
               b_dat, b_ack, b_err, b_busy, b_cnt);
    end
    rst = 1'b0;
    exp_cnt = 16'd0; exp_dat = 128'd0;
  endtask

  task automatic test_fill_read;
    logic ack, err; int lat, bn;
    xfer(32'h0, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++; exp_dat = FILL;
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || lat != WA) begin
      errors++;
      $display("FAIL fill_read_resp: ack=%b err=%b lat=%0d, want 1 0 %0d", ack, err, lat, WA);
    end
    checks++;
    if (a_dat !== FILL) begin
      errors++;
      $display("FAIL fill_read_data: got %h, want %h", a_dat, FILL);
    end
    checks++;
    if (a_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL fill_read_count: got %0d, want %0d", a_cnt, exp_cnt);
    end
  endtask

  task automatic test_preload_read;
    logic ack, err; int lat, bn;
    preload(8'd5, 128'h1);
    xfer(32'h50, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++; exp_dat = 128'h1;
    checks++;
    if (ack !== 1'b1 || a_dat !== exp_dat || bn != 3) begin
      errors++;
      $display("FAIL preload_read: ack=%b dat=%h busy_cycles=%0d, want 1 %h 3",
               ack, a_dat, bn, exp_dat);
    end
    xfer(32'h5C, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++;
    checks++;
    if (ack !== 1'b1 || a_dat !== exp_dat) begin
      errors++;
      $display("FAIL preload_read_lowbits: ack=%b dat=%h, want 1 %h", ack, a_dat, exp_dat);
    end
  endtask

  task automatic test_partial_write;
    logic ack, err; int lat, bn;
    xfer(32'h20, 16'h000F, 1'b1, 128'hAABBCCDD, 1'b0, ack, err, lat, bn);
    exp_cnt++;
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || a_dat !== exp_dat) begin
      errors++;
      $display("FAIL write_resp: ack=%b err=%b dat=%h, want 1 0 %h", ack, err, a_dat, exp_dat);
    end
    xfer(32'h20, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++; exp_dat = 128'hF0801003F0801003F0801003AABBCCDD;
    checks++;
    if (ack !== 1'b1 || a_dat !== exp_dat) begin
      errors++;
      $display("FAIL write_fill_merge: got %h, want %h", a_dat, exp_dat);
    end
    xfer(32'h50, 16'h8000, 1'b1, {8'hEE, 120'd0}, 1'b0, ack, err, lat, bn);
    xfer(32'h50, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt += 16'd2; exp_dat = 128'hEE000000_00000000_00000000_00000001;
    checks++;
    if (a_dat !== exp_dat) begin
      errors++;
      $display("FAIL write_valid_merge: got %h, want %h", a_dat, exp_dat);
    end
    checks++;
    if (a_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL write_count: got %0d, want %0d", a_cnt, exp_cnt);
    end
  endtask

  task automatic test_out_of_range;
    logic ack, err; int lat, bn;
    xfer(32'h1000, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++;
    checks++;
    if (err !== 1'b1 || ack !== 1'b0 || a_dat !== exp_dat || a_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL oor_read: err=%b ack=%b dat=%h cnt=%0d, want 1 0 %h %0d",
               err, ack, a_dat, a_cnt, exp_dat, exp_cnt);
    end
    // Offset 0x1000 aliases index 0 in its low bits; it must not land there.
    xfer(32'h1000, 16'hFFFF, 1'b1, 128'h5, 1'b0, ack, err, lat, bn);
    xfer(32'h0, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt += 16'd2; exp_dat = FILL;
    checks++;
    if (ack !== 1'b1 || a_dat !== FILL) begin
      errors++;
      $display("FAIL oor_write_no_alias: ack=%b dat=%h, want 1 %h", ack, a_dat, FILL);
    end
  endtask

  task automatic test_abort_stb;
    logic ack, err; int lat, bn; bit seen;
    @(negedge clk);
    adr = 32'h70; sel = 16'hFFFF; we = 1'b1; dat = 128'h77; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (a_ack || a_err) seen = 1'b1;
    end
    cyc = 1'b0; we = 1'b0;
    checks++;
    if (seen || a_busy !== 1'b0 || a_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL abort_stb: resp_seen=%b busy=%b cnt=%0d, want 0 0 %0d",
               seen, a_busy, a_cnt, exp_cnt);
    end
    xfer(32'h70, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++;
    checks++;
    if (ack !== 1'b1 || a_dat !== FILL) begin
      errors++;
      $display("FAIL abort_stb_nowrite: dat=%h, want %h", a_dat, FILL);
    end
  endtask

  task automatic test_abort_rst;
    logic ack, err; int lat, bn; bit seen;
    @(negedge clk);
    adr = 32'hA0; sel = 16'hFFFF; we = 1'b1; dat = 128'h99; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (a_ack || a_err) seen = 1'b1;
    end
    exp_cnt = 16'd0;
    checks++;
    if (seen || a_busy !== 1'b0 || a_cnt !== 16'd0 || a_dat !== 128'd0) begin
      errors++;
      $display("FAIL abort_rst: resp_seen=%b busy=%b cnt=%0d dat=%h, want 0 0 0 0",
               seen, a_busy, a_cnt, a_dat);
    end
    xfer(32'hA0, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_cnt++; exp_dat = FILL;
    checks++;
    if (ack !== 1'b1 || a_dat !== FILL || a_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL abort_rst_nowrite: dat=%h cnt=%0d, want %h %0d", a_dat, a_cnt, FILL, exp_cnt);
    end
  endtask

  task automatic test_collision;
    logic ack, err; int lat, bn;
    ld_adr = 8'd9; ld_dat = {16{8'h11}};
    xfer(32'h90, 16'h0001, 1'b1, 128'h22, 1'b1, ack, err, lat, bn);
    xfer(32'h90, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_dat = {{15{8'h11}}, 8'h22};
    checks++;
    if (ack !== 1'b1 || a_dat !== exp_dat) begin
      errors++;
      $display("FAIL collision_write: got %h, want %h", a_dat, exp_dat);
    end
    ld_dat = {16{8'h33}};
    xfer(32'h90, 16'hFFFF, 1'b0, 128'd0, 1'b1, ack, err, lat, bn);
    checks++;
    if (a_dat !== exp_dat) begin
      errors++;
      $display("FAIL collision_read_old: got %h, want %h", a_dat, exp_dat);
    end
    xfer(32'h90, 16'hFFFF, 1'b0, 128'd0, 1'b0, ack, err, lat, bn);
    exp_dat = {16{8'h33}};
    checks++;
    if (a_dat !== exp_dat) begin
      errors++;
      $display("FAIL collision_read_new: got %h, want %h", a_dat, exp_dat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] acks;
    @(negedge clk);
    adr = 32'h30; sel = 16'hFFFF; we = 1'b0; b_cyc = 1'b1; b_stb = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      acks[n] = b_ack;
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (acks !== 8'b0101_0101) begin
      errors++;
      $display("FAIL b2b_ack_pattern: got %b, want 01010101", acks);
    end
    checks++;
    if (b_dat !== FILL || b_cnt !== 16'd4) begin
      errors++;
      $display("FAIL b2b_data_count: dat=%h cnt=%0d, want %h 4", b_dat, b_cnt, FILL);
    end
  endtask

  task automatic test_count_wrap;
    logic [15:0] c1, c2;
    logic        k1, k2;
    @(negedge clk);
    force u_b.o_access_count = 16'hFFFE;
    #1;
    release u_b.o_access_count;
    b_cyc = 1'b1; b_stb = 1'b1;
    @(negedge clk);
    k1 = b_ack; c1 = b_cnt;
    @(negedge clk);
    @(negedge clk);
    k2 = b_ack; c2 = b_cnt;
    b_cyc = 1'b0; b_stb = 1'b0;
    checks++;
    if (k1 !== 1'b1 || c1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_ffff: ack=%b cnt=%h, want 1 ffff", k1, c1);
    end
    checks++;
    if (k2 !== 1'b1 || c2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: ack=%b cnt=%h, want 1 0000", k2, c2);
    end
  endtask

  initial begin
    rst = 1'b1; adr = '0; sel = '0; we = 1'b0; dat = '0;
    cyc = 1'b0; stb = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
    ld_valid = 1'b0; ld_adr = '0; ld_dat = '0;
    test_reset();
    test_abort_rst();
    test_fill_read();
    test_preload_read();
    test_partial_write();
    test_out_of_range();
    test_abort_stb();
    test_collision();
    test_back_to_back();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
